// File: rtl/mem_req_sched.sv
// Two-requester (icache/dcache) memory scheduler: one single-entry buffer per cache, one outstanding
// memory transaction. Define MEM_REQ_SCHED_DCACHE_PRIO_EN for fixed dcache priority (else round-robin).
module mem_req_sched #(
    parameter int unsigned BLOCK_ADDR_W = 26,
    parameter int unsigned BLOCK_DATA_W = 512,
    parameter int unsigned TIMEOUT      = 64
) (
    input  logic                    clk,
    input  logic                    rst_aL,

    input  logic                    icache_req_valid,
    input  logic [BLOCK_ADDR_W-1:0] icache_req_block_addr,
    output logic                    icache_req_ready,
    output logic                    icache_resp_valid,
    output logic [BLOCK_DATA_W-1:0] icache_resp_block_data,

    input  logic                    dcache_req_valid,
    input  logic                    dcache_req_type,
    input  logic [BLOCK_ADDR_W-1:0] dcache_req_block_addr,
    input  logic [BLOCK_DATA_W-1:0] dcache_req_block_data,
    output logic                    dcache_req_ready,
    output logic                    dcache_resp_valid,
    output logic [BLOCK_DATA_W-1:0] dcache_resp_block_data,

    output logic                    mem_req_valid,
    output logic                    mem_req_cache_type,
    output logic                    mem_req_type,
    output logic [BLOCK_ADDR_W-1:0] mem_req_block_addr,
    output logic [BLOCK_DATA_W-1:0] mem_req_block_data,

    input  logic                    mem_resp_valid,
    input  logic                    mem_resp_cache_type,
    input  logic [BLOCK_DATA_W-1:0] mem_resp_block_data,

    output logic                    sched_err
);

    localparam int unsigned CntW = $clog2(TIMEOUT + 1);

    typedef enum logic [0:0] {StIdle, StWait} state_e;

    logic                    ibuf_full_q;
    logic [BLOCK_ADDR_W-1:0] ibuf_addr_q;
    logic                    dbuf_full_q;
    logic                    dbuf_type_q;
    logic [BLOCK_ADDR_W-1:0] dbuf_addr_q;
    logic [BLOCK_DATA_W-1:0] dbuf_data_q;

    state_e                  state_q;
    logic                    grant_q;
    logic [CntW-1:0]         wait_cnt_q;

    logic                    issue;
    logic                    sel_d;   // 0 = icache, 1 = dcache

    assign icache_req_ready = !ibuf_full_q;
    assign dcache_req_ready = !dbuf_full_q;
    assign issue = (state_q == StIdle) && (ibuf_full_q || dbuf_full_q);

`ifdef MEM_REQ_SCHED_DCACHE_PRIO_EN
    always_comb begin
        sel_d = dbuf_full_q;
    end
`else
    logic last_grant_q;

    // On a tie the requester that did not win last time is chosen.
    always_comb begin
        sel_d = dbuf_full_q && (!ibuf_full_q || !last_grant_q);
    end

    always_ff @(posedge clk or negedge rst_aL) begin
        if (!rst_aL) begin
            last_grant_q <= 1'b1;
        end else if (issue) begin
            last_grant_q <= sel_d;
        end
    end
`endif

    always_comb begin
        mem_req_valid      = 1'b0;
        mem_req_cache_type = 1'b0;
        mem_req_type       = 1'b0;
        mem_req_block_addr = '0;
        mem_req_block_data = '0;
        if (issue) begin
            mem_req_valid      = 1'b1;
            mem_req_cache_type = sel_d;
            if (sel_d) begin
                mem_req_type       = dbuf_type_q;
                mem_req_block_addr = dbuf_addr_q;
                mem_req_block_data = dbuf_data_q;
            end else begin
                mem_req_block_addr = ibuf_addr_q;
            end
        end
    end

    // Ready is only high while a buffer is empty, so accept and issue never hit the same buffer.
    always_ff @(posedge clk or negedge rst_aL) begin
        if (!rst_aL) begin
            ibuf_full_q <= 1'b0;
            ibuf_addr_q <= '0;
            dbuf_full_q <= 1'b0;
            dbuf_type_q <= 1'b0;
            dbuf_addr_q <= '0;
            dbuf_data_q <= '0;
        end else begin
            if (issue && !sel_d) begin
                ibuf_full_q <= 1'b0;
            end else if (icache_req_valid && !ibuf_full_q) begin
                ibuf_full_q <= 1'b1;
                ibuf_addr_q <= icache_req_block_addr;
            end
            if (issue && sel_d) begin
                dbuf_full_q <= 1'b0;
            end else if (dcache_req_valid && !dbuf_full_q) begin
                dbuf_full_q <= 1'b1;
                dbuf_type_q <= dcache_req_type;
                dbuf_addr_q <= dcache_req_block_addr;
                dbuf_data_q <= dcache_req_block_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_aL) begin
        if (!rst_aL) begin
            state_q                <= StIdle;
            grant_q                <= 1'b0;
            wait_cnt_q             <= '0;
            icache_resp_valid      <= 1'b0;
            icache_resp_block_data <= '0;
            dcache_resp_valid      <= 1'b0;
            dcache_resp_block_data <= '0;
            sched_err              <= 1'b0;
        end else begin
            icache_resp_valid <= 1'b0;
            dcache_resp_valid <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (mem_resp_valid) begin
                        sched_err <= 1'b1;
                    end
                    if (issue) begin
                        grant_q    <= sel_d;
                        wait_cnt_q <= '0;
                        state_q    <= StWait;
                    end
                end
                StWait: begin
                    if (mem_resp_valid) begin
                        // Routing trusts the latched grant even if the memory tags it otherwise.
                        if (grant_q) begin
                            dcache_resp_valid      <= 1'b1;
                            dcache_resp_block_data <= mem_resp_block_data;
                        end else begin
                            icache_resp_valid      <= 1'b1;
                            icache_resp_block_data <= mem_resp_block_data;
                        end
                        if (mem_resp_cache_type != grant_q) begin
                            sched_err <= 1'b1;
                        end
                        state_q <= StIdle;
                    end else if (wait_cnt_q == CntW'(TIMEOUT - 1)) begin
                        sched_err  <= 1'b1;
                        wait_cnt_q <= '0;
                        state_q    <= StIdle;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + CntW'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_req_sched.sv
// Scoreboard bench for mem_req_sched: a transaction-level model predicts issues and responses,
// a negedge monitor pops and compares whatever the DUT presents.
module tb_mem_req_sched;

    localparam int unsigned AW = 26;
    localparam int unsigned DW = 512;
    localparam int TO = 64;

    logic          clk = 1'b0;
    logic          rst_aL;
    logic          icache_req_valid, icache_req_ready, icache_resp_valid;
    logic [AW-1:0] icache_req_block_addr;
    logic [DW-1:0] icache_resp_block_data;
    logic          dcache_req_valid, dcache_req_type, dcache_req_ready, dcache_resp_valid;
    logic [AW-1:0] dcache_req_block_addr;
    logic [DW-1:0] dcache_req_block_data, dcache_resp_block_data;
    logic          mem_req_valid, mem_req_cache_type, mem_req_type;
    logic [AW-1:0] mem_req_block_addr;
    logic [DW-1:0] mem_req_block_data;
    logic          mem_resp_valid, mem_resp_cache_type;
    logic [DW-1:0] mem_resp_block_data;
    logic          sched_err;

    mem_req_sched dut (
        .clk                    (clk),
        .rst_aL                 (rst_aL),
        .icache_req_valid       (icache_req_valid),
        .icache_req_block_addr  (icache_req_block_addr),
        .icache_req_ready       (icache_req_ready),
        .icache_resp_valid      (icache_resp_valid),
        .icache_resp_block_data (icache_resp_block_data),
        .dcache_req_valid       (dcache_req_valid),
        .dcache_req_type        (dcache_req_type),
        .dcache_req_block_addr  (dcache_req_block_addr),
        .dcache_req_block_data  (dcache_req_block_data),
        .dcache_req_ready       (dcache_req_ready),
        .dcache_resp_valid      (dcache_resp_valid),
        .dcache_resp_block_data (dcache_resp_block_data),
        .mem_req_valid          (mem_req_valid),
        .mem_req_cache_type     (mem_req_cache_type),
        .mem_req_type           (mem_req_type),
        .mem_req_block_addr     (mem_req_block_addr),
        .mem_req_block_data     (mem_req_block_data),
        .mem_resp_valid         (mem_resp_valid),
        .mem_resp_cache_type    (mem_resp_cache_type),
        .mem_resp_block_data    (mem_resp_block_data),
        .sched_err              (sched_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] d;
        for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    // Reference model: pending request per requester, one outstanding transaction.
    typedef struct {
        bit            ct;
        bit            ty;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } req_t;
    typedef struct {
        bit            d;
        logic [DW-1:0] data;
    } resp_t;

    req_t  exp_mem_q[$];
    resp_t exp_resp_q[$];
    req_t  m_buf[2];
    bit    m_pend[2];
    bit    m_busy, m_grant, m_last, m_err;
    int    m_cnt;

    function automatic bit pick();
        if (m_pend[0] && m_pend[1]) begin
`ifdef MEM_REQ_SCHED_DCACHE_PRIO_EN
            return 1'b1;
`else
            return !m_last;
`endif
        end
        return m_pend[1];
    endfunction

    initial begin
        forever begin
            @(posedge clk or negedge rst_aL);
            if (!rst_aL) begin
                m_pend = '{0, 0};
                m_busy = 0; m_last = 1; m_err = 0; m_cnt = 0; m_grant = 0;
                exp_mem_q.delete();
                exp_resp_q.delete();
            end else begin
                bit rdy_i, rdy_d;
                rdy_i = !m_pend[0];
                rdy_d = !m_pend[1];
                if (m_busy) begin
                    if (mem_resp_valid) begin
                        resp_t r;
                        r.d = m_grant;
                        r.data = mem_resp_block_data;
                        exp_resp_q.push_back(r);
                        if (mem_resp_cache_type != m_grant) m_err = 1;
                        m_busy = 0;
                    end else begin
                        m_cnt++;
                        if (m_cnt == TO) begin
                            m_err = 1;
                            m_busy = 0;
                        end
                    end
                end else begin
                    if (mem_resp_valid) m_err = 1;
                    if (m_pend[0] || m_pend[1]) begin
                        m_grant = pick();
                        m_pend[m_grant] = 0;
                        m_last = m_grant;
                        m_busy = 1;
                        m_cnt = 0;
                    end
                end
                if (icache_req_valid && rdy_i) begin
                    m_pend[0] = 1;
                    m_buf[0] = '{0, 0, icache_req_block_addr, '0};
                end
                if (dcache_req_valid && rdy_d) begin
                    m_pend[1] = 1;
                    m_buf[1] = '{1, dcache_req_type, dcache_req_block_addr, dcache_req_block_data};
                end
                if (!m_busy && (m_pend[0] || m_pend[1])) exp_mem_q.push_back(m_buf[pick()]);
            end
        end
    end

    // Memory responder state shared between monitor (sets) and driver (consumes).
    bit            rsp_pend = 0;
    bit            rsp_ct;
    int            rsp_dly;
    int            fix_dly = -1;
    bit            use_fix_data = 0;
    logic [DW-1:0] fix_data;
    bit            err_en = 0, flip_ct = 0, force_stray = 0, auto_drv = 0;
    int            rate_i = 0, rate_d = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_aL) continue;
            if (mem_req_valid) begin
                chk("mem_req_expected", DW'(exp_mem_q.size() != 0), DW'(1));
                if (exp_mem_q.size() != 0) begin
                    req_t e;
                    e = exp_mem_q.pop_front();
                    chk("mem_req_cache_type", DW'(mem_req_cache_type), DW'(e.ct));
                    chk("mem_req_type", DW'(mem_req_type), DW'(e.ty));
                    chk("mem_req_addr", DW'(mem_req_block_addr), DW'(e.addr));
                    chk("mem_req_data", mem_req_block_data, e.data);
                end
                rsp_pend = 1;
                rsp_ct = mem_req_cache_type;
                if (fix_dly >= 0) rsp_dly = fix_dly;
                else if (err_en && $urandom_range(0, 9) == 0) rsp_dly = 80;
                else rsp_dly = $urandom_range(0, 6);
            end else begin
                chk("mem_req_idle_zero", DW'(|{mem_req_cache_type, mem_req_type,
                    mem_req_block_addr, mem_req_block_data}), DW'(0));
            end
            if (icache_resp_valid || dcache_resp_valid) begin
                chk("resp_exclusive", DW'(icache_resp_valid && dcache_resp_valid), DW'(0));
                chk("resp_expected", DW'(exp_resp_q.size() != 0), DW'(1));
                if (exp_resp_q.size() != 0) begin
                    resp_t e;
                    e = exp_resp_q.pop_front();
                    chk("resp_port_is_dcache", DW'(dcache_resp_valid), DW'(e.d));
                    chk("resp_data", e.d ? dcache_resp_block_data : icache_resp_block_data,
                        e.data);
                end
            end
            chk("icache_ready", DW'(icache_req_ready), DW'(!m_pend[0]));
            chk("dcache_ready", DW'(dcache_req_ready), DW'(!m_pend[1]));
            chk("sched_err", DW'(sched_err), DW'(m_err));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (auto_drv) begin
            icache_req_valid      = $urandom_range(0, 99) < rate_i;
            icache_req_block_addr = AW'($urandom);
            dcache_req_valid      = $urandom_range(0, 99) < rate_d;
            dcache_req_type       = 1'($urandom);
            dcache_req_block_addr = AW'($urandom);
            dcache_req_block_data = rand_data();
        end
        if (force_stray) begin
            mem_resp_valid      = 1;
            mem_resp_cache_type = 1'($urandom);
            mem_resp_block_data = rand_data();
            force_stray = 0;
        end else if (rsp_pend && rsp_dly == 0) begin
            mem_resp_valid      = 1;
            mem_resp_cache_type = rsp_ct ^ (flip_ct || (err_en && $urandom_range(0, 7) == 0));
            mem_resp_block_data = use_fix_data ? fix_data : rand_data();
            rsp_pend = 0;
            flip_ct = 0;
        end else begin
            mem_resp_valid      = err_en && !rsp_pend && $urandom_range(0, 63) == 0;
            mem_resp_cache_type = 1'($urandom);
            mem_resp_block_data = rand_data();
            if (rsp_pend) rsp_dly--;
        end
    endtask

    task automatic clear_reqs();
        icache_req_valid = 0;
        dcache_req_valid = 0;
    endtask

    task automatic do_reset();
        rst_aL = 0;
        #1;
        chk("rst_mem_req_valid", DW'(mem_req_valid), DW'(0));
        chk("rst_resp_valid", DW'({icache_resp_valid, dcache_resp_valid}), DW'(0));
        chk("rst_sched_err", DW'(sched_err), DW'(0));
        chk("rst_ready", DW'({icache_req_ready, dcache_req_ready}), DW'(2'b11));
        rsp_pend = 0;
        mem_resp_valid = 0;
        clear_reqs();
        repeat (2) @(posedge clk);
        #2;
        rst_aL = 1;
    endtask

    initial begin
        rst_aL = 1;
        clear_reqs();
        icache_req_block_addr = '0;
        dcache_req_type = 0;
        dcache_req_block_addr = '0;
        dcache_req_block_data = '0;
        mem_resp_valid = 0;
        mem_resp_cache_type = 0;
        mem_resp_block_data = '0;
        fix_data = '0;
        #2;
        do_reset();

        // Single icache read, response on the fifth WAIT cycle.
        fix_data = {64{8'hAB}};
        use_fix_data = 1;
        fix_dly = 4;
        step(); icache_req_valid = 1; icache_req_block_addr = AW'(32'h10);
        step(); clear_reqs();
        repeat (12) step();
        use_fix_data = 0;

        // Simultaneous icache read and dcache write.
        fix_dly = 2;
        step();
        icache_req_valid = 1; icache_req_block_addr = AW'(32'h1);
        dcache_req_valid = 1; dcache_req_type = 1; dcache_req_block_addr = AW'(32'h2);
        dcache_req_block_data = rand_data();
        step(); clear_reqs();
        repeat (20) step();

        // Both requesters saturated.
        fix_dly = -1;
        rate_i = 100; rate_d = 100; auto_drv = 1;
        repeat (40) step();
        auto_drv = 0; clear_reqs();
        repeat (20) step();

        // Wrong cache type on response, then a stray response in IDLE.
        fix_dly = 1; flip_ct = 1;
        step(); icache_req_valid = 1; icache_req_block_addr = AW'($urandom);
        step(); clear_reqs();
        repeat (8) step();
        force_stray = 1;
        repeat (5) step();

        // Timeout with a second request buffered behind it.
        fix_dly = 80;
        step(); icache_req_valid = 1; icache_req_block_addr = AW'($urandom);
        step(); icache_req_valid = 0;
        dcache_req_valid = 1; dcache_req_type = 0; dcache_req_block_addr = AW'($urandom);
        step(); clear_reqs();
        repeat (150) step();

        // Reset while waiting, then a late response lands in IDLE.
        fix_dly = 10;
        step(); icache_req_valid = 1; icache_req_block_addr = AW'($urandom);
        step(); clear_reqs();
        repeat (3) step();
        #2;
        do_reset();
        repeat (15) step();
        force_stray = 1;
        repeat (5) step();

        // Random traffic, error-free.
        do_reset();
        fix_dly = -1;
        rate_i = 40; rate_d = 40; auto_drv = 1;
        repeat (800) step();
        auto_drv = 0; clear_reqs();
        repeat (20) step();

        // Random traffic with timeouts, stray and mistagged responses.
        err_en = 1;
        rate_i = 30; rate_d = 50; auto_drv = 1;
        repeat (800) step();
        auto_drv = 0; clear_reqs(); err_en = 0;
        repeat (200) step();

        @(negedge clk);
        chk("exp_mem_drained", DW'(exp_mem_q.size()), DW'(0));
        chk("exp_resp_drained", DW'(exp_resp_q.size()), DW'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_req_sched.md
MEM_REQ_SCHED -- requirements
Module: mem_req_sched

Interface
REQ-001 SHALL have parameter BLOCK_ADDR_W, default 26, main-memory block address width.
REQ-002 SHALL have parameter BLOCK_DATA_W, default 512, cache block data width.
REQ-003 SHALL have parameter TIMEOUT, default 64, max WAIT cycles before abort.
REQ-004 SHALL have ports: clk  in  1  single clock; all state on rising edge.
REQ-005 SHALL have ports: rst_aL  in  1  asynchronous, active-low reset.
REQ-006 SHALL have ports: icache_req_valid in 1; icache_req_block_addr in BLOCK_ADDR_W; icache_req_ready out 1 (icache read request).
REQ-007 SHALL have ports: icache_resp_valid out 1; icache_resp_block_data out BLOCK_DATA_W (icache response).
REQ-008 SHALL have ports: dcache_req_valid in 1; dcache_req_type in 1 (0 read, 1 write); dcache_req_block_addr in BLOCK_ADDR_W; dcache_req_block_data in BLOCK_DATA_W; dcache_req_ready out 1.
REQ-009 SHALL have ports: dcache_resp_valid out 1; dcache_resp_block_data out BLOCK_DATA_W.
REQ-010 SHALL have ports: mem_req_valid out 1; mem_req_cache_type out 1 (0 icache, 1 dcache); mem_req_type out 1; mem_req_block_addr out BLOCK_ADDR_W; mem_req_block_data out BLOCK_DATA_W.
REQ-011 SHALL have ports: mem_resp_valid in 1; mem_resp_cache_type in 1; mem_resp_block_data in BLOCK_DATA_W.
REQ-012 SHALL have ports: sched_err  out  1  sticky protocol/timeout error flag.

Function
REQ-013 SHALL hold one single-entry buffer per requester; *_req_ready = buffer empty (registered, no combinational path from valid).
REQ-014 SHALL capture addr/type/data into the buffer on valid&&ready at a clock edge; buffer full from next cycle.
REQ-015 SHALL implement FSM states IDLE and WAIT only; one memory transaction outstanding at a time.
REQ-016 In IDLE with >=1 buffer full, SHALL combinationally assert mem_req_valid for exactly that cycle with the granted buffer's fields, free that buffer at the edge, latch grant, clear wait counter, go to WAIT.
REQ-017 Grant: only one full -> that one; both full -> requester != last_grant (round-robin); last_grant updated on every issue.
REQ-018 For icache grants, mem_req_type SHALL be 0 and mem_req_block_data SHALL be 0.
REQ-019 In IDLE with no buffer full, mem_req_valid SHALL be 0 and all mem_req_* fields 0.
REQ-020 In WAIT, on mem_resp_valid, SHALL register data to the granted requester: *_resp_valid high exactly one cycle after mem_resp_valid, data held with it; FSM returns to IDLE next edge.
REQ-021 Writes SHALL also complete via mem_resp_valid; dcache_resp_valid pulses for writes, data = mem_resp_block_data.
REQ-022 Response routing SHALL follow the latched grant; mem_resp_cache_type != grant SHALL set sched_err.
REQ-023 mem_resp_valid in IDLE SHALL be ignored and set sched_err.
REQ-024 Wait counter increments each WAIT cycle without response; reaching TIMEOUT SHALL set sched_err, return to IDLE, issue no response.
REQ-025 A requester's buffer freed at issue SHALL allow a new request accept the following cycle (back-to-back issue min spacing = one full transaction).
REQ-026 Min latency: request accepted at edge N -> mem_req_valid in cycle N+1 (FSM idle).
REQ-027 *_resp_valid outputs SHALL never both be 1 in the same cycle.

Reset
REQ-028 rst_aL low SHALL asynchronously force: FSM IDLE, both buffers empty, both ready 1 after release, last_grant = dcache (icache wins first tie), counter 0, all resp/mem_req outputs 0, sched_err 0.
REQ-029 Reset mid-WAIT SHALL drop the outstanding transaction; a later mem_resp_valid is treated per REQ-023.

Configuration
REQ-030 Macro MEM_REQ_SCHED_DCACHE_PRIO_EN defined: when both buffers full, dcache SHALL always win; last_grant unused.
REQ-031 Macro undefined: round-robin per REQ-017.

Verification
REQ-032 Reset, icache req addr 0x10 -> mem_req_valid next cycle, cache_type 0, type 0; mem_resp data 0xAB.. at WAIT cycle 5 -> icache_resp_valid 1 cycle later with 0xAB...
REQ-033 Both requests same edge after reset (icache 0x1, dcache write 0x2) -> icache issued first, dcache second; dcache_resp_valid on write ack; with DCACHE_PRIO_EN dcache first.
REQ-034 Both requesters re-request continuously, 4 transactions -> grants alternate I,D,I,D.
REQ-035 No mem response for 64 WAIT cycles -> sched_err=1, FSM IDLE, next buffered request issues next cycle.
REQ-036 mem_resp_valid in IDLE, and mem_resp_cache_type=1 during icache grant -> sched_err=1; icache still receives data.
REQ-037 rst_aL low during WAIT -> outputs zero immediately, readies 1 after release, no resp pulse.
